// File: rtl/btb_wr_arb_pkg.sv
// Shared BTB types: branch-type encodings, field widths, write-port grant
// encoding and the entry layouts used by the BTB write arbiter.
package btb_pkg;

  localparam int BR_POS_W   = 3;
  localparam int BR_TYP_W   = 2;
  localparam int RAS_CTL_W  = 2;
  localparam int PC_W       = 64;
  localparam int RT_ENTRY_W = 1 + 2 * PC_W;

  localparam logic [BR_TYP_W-1:0] BR_COND      = 2'd0;
  localparam logic [BR_TYP_W-1:0] BR_UNCOND    = 2'd1;
  localparam logic [BR_TYP_W-1:0] BR_INDIR_RAS = 2'd2;
  localparam logic [BR_TYP_W-1:0] BR_INDIR_PC  = 2'd3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_SP   = 2'd1,
    GNT_RT   = 2'd2
  } gnt_e;

  typedef struct packed {
    logic                 brdir;
    logic [PC_W-1:0]      brpc;
    logic [PC_W-1:0]      tar;
  } rt_entry_t;

  typedef struct packed {
    logic [BR_POS_W-1:0]  brpos;
    logic [BR_TYP_W-1:0]  brtyp;
    logic [PC_W-1:0]      brpc;
    logic [PC_W-1:0]      brtar;
    logic [RAS_CTL_W-1:0] rasctl;
  } sp_entry_t;

  // Retire work wins when the queue is full, when speculation has had its
  // quota of consecutive grants, or when there is no speculative entry.
  function automatic gnt_e pick_grant(input logic fifo_empty,
                                      input logic fifo_full,
                                      input logic starve_hit,
                                      input logic sp_vld);
    gnt_e g;
    if (!fifo_empty && (fifo_full || starve_hit || !sp_vld)) begin
      g = GNT_RT;
    end else if (sp_vld) begin
      g = GNT_SP;
    end else begin
      g = GNT_NONE;
    end
    return g;
  endfunction

endpackage

// File: rtl/btb_wr_arb_if.sv
// Fetch1 / retire / BTB-write-port signal bundle of the BTB write arbiter.
interface btb_wr_arb_if;
  import btb_pkg::*;

  logic                 flush_i;
  logic                 sp_req_i;
  logic [BR_POS_W-1:0]  sp_brpos_i;
  logic [BR_TYP_W-1:0]  sp_brtyp_i;
  logic [PC_W-1:0]      sp_brpc_i;
  logic [PC_W-1:0]      sp_brtar_i;
  logic [RAS_CTL_W-1:0] sp_rasctl_i;

  logic                 rt_valid_i;
  logic                 rt_ready_o;
  logic                 rt_brdir_i;
  logic [PC_W-1:0]      rt_brpc_i;
  logic [PC_W-1:0]      rt_tar_i;

  logic                 btb_sp_we_o;
  logic [BR_POS_W-1:0]  btb_sp_brpos_o;
  logic [BR_TYP_W-1:0]  btb_sp_brtyp_o;
  logic [PC_W-1:0]      btb_sp_brpc_o;
  logic [PC_W-1:0]      btb_sp_brtar_o;
  logic [RAS_CTL_W-1:0] btb_ras_ctl_o;
  logic                 btb_rt_we_o;
  logic                 btb_rt_brdir_o;
  logic [PC_W-1:0]      btb_rt_brpc_o;
  logic [PC_W-1:0]      btb_taken_addr_o;
  logic                 sp_drop_o;

  modport master (
    output flush_i, sp_req_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i,
           sp_rasctl_i, rt_valid_i, rt_brdir_i, rt_brpc_i, rt_tar_i,
    input  rt_ready_o, btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o,
           btb_sp_brpc_o, btb_sp_brtar_o, btb_ras_ctl_o, btb_rt_we_o,
           btb_rt_brdir_o, btb_rt_brpc_o, btb_taken_addr_o, sp_drop_o
  );

  modport slave (
    input  flush_i, sp_req_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i,
           sp_rasctl_i, rt_valid_i, rt_brdir_i, rt_brpc_i, rt_tar_i,
    output rt_ready_o, btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o,
           btb_sp_brpc_o, btb_sp_brtar_o, btb_ras_ctl_o, btb_rt_we_o,
           btb_rt_brdir_o, btb_rt_brpc_o, btb_taken_addr_o, sp_drop_o
  );

endinterface

// File: rtl/btb_rt_fifo.sv
// In-order synchronous FIFO holding retire-stage BTB updates {brdir, brpc, tar}.
module btb_rt_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  rt_entry_t        wdata,
  input  logic             pop,
  output rt_entry_t        rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  rt_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == CNT_W'(1'b0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_W'(1'b0);
      rd_ptr_r <= PTR_W'(1'b0);
      count_r  <= CNT_W'(1'b0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + CNT_W'(1'b1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_r <= count_r - CNT_W'(1'b1);
      end
    end
  end

  // Storage array; contents are qualified by count so they need no reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/btb_wr_arb_chk.sv
// Invariants of the BTB write arbiter: single write per cycle and bounded
// retire latency.
module btb_wr_arb_chk #(
  parameter int STARVE_MAX = 3,
  parameter int ST_W       = 2
) (
  input logic            clock,
  input logic            reset_n,
  input logic            sp_we,
  input logic            rt_we,
  input logic            fifo_empty,
  input logic            fifo_full,
  input logic [ST_W-1:0] starve
);

  a_one_write: assert property (@(posedge clock) disable iff (!reset_n)
    !(sp_we && rt_we));

  a_rt_has_data: assert property (@(posedge clock) disable iff (!reset_n)
    rt_we |-> !fifo_empty);

  a_starve_range: assert property (@(posedge clock) disable iff (!reset_n)
    starve <= ST_W'(STARVE_MAX));

  a_full_drains: assert property (@(posedge clock) disable iff (!reset_n)
    fifo_full |-> rt_we);

  a_starve_drains: assert property (@(posedge clock) disable iff (!reset_n)
    (!fifo_empty && starve == ST_W'(STARVE_MAX)) |-> rt_we);

endmodule

// File: rtl/btb_wr_arb.sv
// Single-write-port BTB arbiter: droppable speculative allocations from fetch1
// versus lossless, in-order retire updates with a starvation bound.
module btb_wr_arb
  import btb_pkg::*;
#(
  parameter int RT_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input logic         clock,
  input logic         reset_n,
  btb_wr_arb_if.slave bus
);

  localparam int CNT_W = $clog2(RT_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(RT_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_TOP = ST_W'(STARVE_MAX);

  sp_entry_t        sp_hold_r;
  logic             sp_vld_r;
  logic             drop_r;
  logic             ready_en_r;
  logic [ST_W-1:0]  starve_r;

  gnt_e             gnt_s;
  rt_entry_t        push_data_s;
  rt_entry_t        head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             rt_ready_s;
  logic             push_s;
  logic             pop_s;

  assign gnt_s       = pick_grant(fifo_empty_s, fifo_full_s,
                                  starve_r == STARVE_TOP, sp_vld_r);
  // ready_en_r keeps rt_ready_o low while reset is held.
  assign rt_ready_s  = ready_en_r && (fifo_count_s < FULL_CNT);
  assign push_s      = bus.rt_valid_i && rt_ready_s;
  assign pop_s       = (gnt_s == GNT_RT);
  assign push_data_s = '{brdir: bus.rt_brdir_i, brpc: bus.rt_brpc_i, tar: bus.rt_tar_i};

  btb_rt_fifo #(
    .DEPTH (RT_DEPTH),
    .CNT_W (CNT_W)
  ) u_rt_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .wdata   (push_data_s),
    .pop     (pop_s),
    .rdata   (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Speculative holding register: flush beats a new request, newest request wins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sp_vld_r  <= 1'b0;
      sp_hold_r <= {$bits(sp_entry_t){1'b0}};
      drop_r    <= 1'b0;
    end else begin
      drop_r <= 1'b0;
      if (bus.flush_i) begin
        sp_vld_r <= 1'b0;
      end else if (bus.sp_req_i) begin
        sp_vld_r  <= 1'b1;
        sp_hold_r <= '{brpos:  bus.sp_brpos_i,
                       brtyp:  bus.sp_brtyp_i,
                       brpc:   bus.sp_brpc_i,
                       brtar:  bus.sp_brtar_i,
                       rasctl: bus.sp_rasctl_i};
        drop_r    <= sp_vld_r && (gnt_s != GNT_SP);
      end else if (gnt_s == GNT_SP) begin
        sp_vld_r <= 1'b0;
      end
    end
  end

  // Starvation counter: counts SP grants taken while retire work waits.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_r <= ST_W'(1'b0);
    end else if (pop_s || fifo_empty_s) begin
      starve_r <= ST_W'(1'b0);
    end else if ((gnt_s == GNT_SP) && (starve_r != STARVE_TOP)) begin
      starve_r <= starve_r + ST_W'(1'b1);
    end
  end

  // Retire-ready enable, low while reset is asserted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Write-port drive from registered state, masked by the grant.
  always_comb begin
    bus.btb_sp_we_o      = 1'b0;
    bus.btb_sp_brpos_o   = {BR_POS_W{1'b0}};
    bus.btb_sp_brtyp_o   = {BR_TYP_W{1'b0}};
    bus.btb_sp_brpc_o    = {PC_W{1'b0}};
    bus.btb_sp_brtar_o   = {PC_W{1'b0}};
    bus.btb_ras_ctl_o    = {RAS_CTL_W{1'b0}};
    bus.btb_rt_we_o      = 1'b0;
    bus.btb_rt_brdir_o   = 1'b0;
    bus.btb_rt_brpc_o    = {PC_W{1'b0}};
    bus.btb_taken_addr_o = {PC_W{1'b0}};
    case (gnt_s)
      GNT_SP: begin
        bus.btb_sp_we_o    = 1'b1;
        bus.btb_sp_brpos_o = sp_hold_r.brpos;
        bus.btb_sp_brtyp_o = sp_hold_r.brtyp;
        bus.btb_sp_brpc_o  = sp_hold_r.brpc;
        bus.btb_sp_brtar_o = sp_hold_r.brtar;
        bus.btb_ras_ctl_o  = sp_hold_r.rasctl;
      end
      GNT_RT: begin
        bus.btb_rt_we_o      = 1'b1;
        bus.btb_rt_brdir_o   = head_s.brdir;
        bus.btb_rt_brpc_o    = head_s.brpc;
        bus.btb_taken_addr_o = head_s.tar;
      end
      default: begin
        bus.btb_sp_we_o = 1'b0;
        bus.btb_rt_we_o = 1'b0;
      end
    endcase
  end

  assign bus.rt_ready_o = rt_ready_s;
  assign bus.sp_drop_o  = drop_r;

  btb_wr_arb_chk #(
    .STARVE_MAX (STARVE_MAX),
    .ST_W       (ST_W)
  ) u_chk (
    .clock      (clock),
    .reset_n    (reset_n),
    .sp_we      (bus.btb_sp_we_o),
    .rt_we      (bus.btb_rt_we_o),
    .fifo_empty (fifo_empty_s),
    .fifo_full  (fifo_full_s),
    .starve     (starve_r)
  );

endmodule

// File: tb/tb_btb_wr_arb.sv
// Bench for btb_wr_arb: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the arbitration rules.
module tb_btb_wr_arb;
  import btb_pkg::*;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  btb_wr_arb_if bus();

  btb_wr_arb #(.RT_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        dir;
    logic [63:0] pc;
    logic [63:0] tar;
  } rt_m_t;

  // model state
  rt_m_t       q[$];
  bit          sp_v;
  logic [2:0]  sp_pos;
  logic [1:0]  sp_typ;
  logic [1:0]  sp_ras;
  logic [63:0] sp_pc;
  logic [63:0] sp_tar;
  int          st;
  bit          ready_en;
  bit          drop;
  bit          known = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = none, 1 = speculative, 2 = retire
  function automatic int m_gnt();
    if (q.size() > 0 && (q.size() == DEPTH || st == SMAX || !sp_v)) return 2;
    if (sp_v) return 1;
    return 0;
  endfunction

  function automatic bit m_ready();
    return ready_en && (q.size() < DEPTH);
  endfunction

  task automatic model_step();
    int g;
    bit push;
    rt_m_t e;
    if (!reset_n) begin
      q.delete();
      sp_v = 1'b0; st = 0; ready_en = 1'b0; drop = 1'b0; known = 1'b1;
    end else if (known) begin
      g    = m_gnt();
      push = bus.rt_valid_i && m_ready();
      drop = !bus.flush_i && bus.sp_req_i && sp_v && (g != 1);
      if (bus.flush_i) sp_v = 1'b0;
      else if (bus.sp_req_i) begin
        sp_v = 1'b1;
        sp_pos = bus.sp_brpos_i; sp_typ = bus.sp_brtyp_i; sp_ras = bus.sp_rasctl_i;
        sp_pc = bus.sp_brpc_i; sp_tar = bus.sp_brtar_i;
      end else if (g == 1) sp_v = 1'b0;
      if (g == 2 || q.size() == 0) st = 0;
      else if (g == 1 && st < SMAX) st = st + 1;
      if (g == 2) void'(q.pop_front());
      if (push) begin
        e.dir = bus.rt_brdir_i; e.pc = bus.rt_brpc_i; e.tar = bus.rt_tar_i;
        q.push_back(e);
      end
      ready_en = 1'b1;
    end
  endtask

  task automatic compare();
    int g;
    rt_m_t h;
    if (known) begin
      g = m_gnt();
      h = (q.size() > 0) ? q[0] : '0;
      chk("sp_we",    bus.btb_sp_we_o,      64'(g == 1));
      chk("sp_brpos", bus.btb_sp_brpos_o,   (g == 1) ? 64'(sp_pos) : 64'd0);
      chk("sp_brtyp", bus.btb_sp_brtyp_o,   (g == 1) ? 64'(sp_typ) : 64'd0);
      chk("sp_brpc",  bus.btb_sp_brpc_o,    (g == 1) ? sp_pc : 64'd0);
      chk("sp_brtar", bus.btb_sp_brtar_o,   (g == 1) ? sp_tar : 64'd0);
      chk("ras_ctl",  bus.btb_ras_ctl_o,    (g == 1) ? 64'(sp_ras) : 64'd0);
      chk("rt_we",    bus.btb_rt_we_o,      64'(g == 2));
      chk("rt_brdir", bus.btb_rt_brdir_o,   (g == 2) ? 64'(h.dir) : 64'd0);
      chk("rt_brpc",  bus.btb_rt_brpc_o,    (g == 2) ? h.pc : 64'd0);
      chk("taken",    bus.btb_taken_addr_o, (g == 2) ? h.tar : 64'd0);
      chk("rt_ready", bus.rt_ready_o,       64'(m_ready()));
      chk("sp_drop",  bus.sp_drop_o,        64'(drop));
    end
  endtask

  // model advances on each edge, outputs compared mid-cycle
  initial begin
    forever begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare();
    end
  end

  task automatic idle_inputs();
    bus.flush_i = 1'b0; bus.sp_req_i = 1'b0; bus.sp_brpos_i = 3'd0; bus.sp_brtyp_i = 2'd0;
    bus.sp_brpc_i = 64'd0; bus.sp_brtar_i = 64'd0; bus.sp_rasctl_i = 2'd0;
    bus.rt_valid_i = 1'b0; bus.rt_brdir_i = 1'b0; bus.rt_brpc_i = 64'd0; bus.rt_tar_i = 64'd0;
  endtask

  task automatic sp(input logic [63:0] pc, input logic [63:0] tar);
    bus.sp_req_i = 1'b1; bus.sp_brpc_i = pc; bus.sp_brtar_i = tar;
    bus.sp_brtyp_i = BR_COND; bus.sp_brpos_i = 3'd5; bus.sp_rasctl_i = 2'd1;
  endtask

  task automatic rt(input logic [63:0] pc);
    bus.rt_valid_i = 1'b1; bus.rt_brpc_i = pc; bus.rt_tar_i = pc + 64'h1000; bus.rt_brdir_i = pc[6];
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  logic acc;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    step(); step();
    chk("rst_ready", bus.rt_ready_o, 64'd0);
    chk("rst_sp_we", bus.btb_sp_we_o, 64'd0);
    chk("rst_rt_we", bus.btb_rt_we_o, 64'd0);
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", bus.rt_ready_o, 64'd1);

    // 1: single speculative allocation
    sp(64'h1000, 64'h2000);
    step();
    idle_inputs();
    chk("t1_sp_we", bus.btb_sp_we_o, 64'd1);
    chk("t1_pc", bus.btb_sp_brpc_o, 64'h1000);
    chk("t1_tar", bus.btb_sp_brtar_o, 64'h2000);
    chk("t1_typ", bus.btb_sp_brtyp_o, 64'(BR_COND));
    chk("t1_rt_we", bus.btb_rt_we_o, 64'd0);
    step();
    chk("t1_once", bus.btb_sp_we_o, 64'd0);

    // 2: back-to-back retire updates, drained in order
    rt(64'h40); step();
    chk("t2_we0", bus.btb_rt_we_o, 64'd1); chk("t2_pc0", bus.btb_rt_brpc_o, 64'h40);
    rt(64'h80); step();
    chk("t2_we1", bus.btb_rt_we_o, 64'd1); chk("t2_pc1", bus.btb_rt_brpc_o, 64'h80);
    rt(64'hC0); step();
    chk("t2_we2", bus.btb_rt_we_o, 64'd1); chk("t2_pc2", bus.btb_rt_brpc_o, 64'hC0);
    idle_inputs(); step();
    chk("t2_done", bus.btb_rt_we_o, 64'd0);

    // 3: starvation bound with one queued retire update
    sp(64'hA00, 64'hB00); rt(64'h100); step();
    bus.rt_valid_i = 1'b0;
    chk("t3_sp0", bus.btb_sp_we_o, 64'd1);
    for (int i = 1; i <= 4; i++) begin
      sp(64'hA00 + 64'(i * 16), 64'hB00); step();
      if (i < 3) begin
        chk("t3_sp", bus.btb_sp_we_o, 64'd1); chk("t3_nodrop", bus.sp_drop_o, 64'd0);
      end else if (i == 3) begin
        chk("t3_rt", bus.btb_rt_we_o, 64'd1); chk("t3_rtpc", bus.btb_rt_brpc_o, 64'h100);
      end else begin
        chk("t3_drop", bus.sp_drop_o, 64'd1); chk("t3_newest", bus.btb_sp_brpc_o, 64'hA40);
      end
    end
    idle_inputs(); step();

    // 4: fill the retire queue under continuous speculative traffic
    for (int i = 0; i < 4; i++) begin
      rt(64'h200 + 64'(i * 64)); sp(64'hC00 + 64'(i), 64'hD00); step();
    end
    chk("t4_full_ready", bus.rt_ready_o, 64'd0);
    chk("t4_full_rt", bus.btb_rt_we_o, 64'd1);
    chk("t4_head", bus.btb_rt_brpc_o, 64'h200);
    rt(64'h300); sp(64'hC10, 64'hD00); step();
    chk("t4_ready_back", bus.rt_ready_o, 64'd1);
    step();
    idle_inputs();
    for (int k = 0; k < 20 && q.size() > 0; k++) step();
    chk("t4_drain_bound", 64'(q.size()), 64'd0);
    step();

    // 5: flush discards the simultaneous request
    sp(64'h500, 64'h510); step();
    chk("t5_500", bus.btb_sp_brpc_o, 64'h500);
    bus.flush_i = 1'b1; sp(64'h600, 64'h610); step();
    idle_inputs();
    chk("t5_no_we", bus.btb_sp_we_o, 64'd0);
    chk("t5_no_drop", bus.sp_drop_o, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step(); chk("t5_never600", bus.btb_sp_we_o, 64'd0);
    end

    // 6: reset with queued retire work and a pending speculative entry
    rt(64'h700); sp(64'hE00, 64'hE10); step();
    rt(64'h740); sp(64'hE20, 64'hE30); step();
    idle_inputs();
    reset_n = 1'b0; step();
    chk("t6_ready_rst", bus.rt_ready_o, 64'd0);
    chk("t6_sp_we", bus.btb_sp_we_o, 64'd0);
    chk("t6_rt_we", bus.btb_rt_we_o, 64'd0);
    chk("t6_drop", bus.sp_drop_o, 64'd0);
    reset_n = 1'b1; step();
    chk("t6_ready", bus.rt_ready_o, 64'd1);
    for (int k = 0; k < 2; k++) begin
      step(); chk("t6_quiet", 64'(bus.btb_sp_we_o | bus.btb_rt_we_o), 64'd0);
    end

    // random traffic; the retire producer holds each update until accepted
    acc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      reset_n         = ($urandom_range(0, 249) != 0);
      bus.flush_i     = ($urandom_range(0, 7) == 0);
      bus.sp_req_i    = ($urandom_range(0, 3) != 0);
      bus.sp_brpos_i  = 3'($urandom());
      bus.sp_brtyp_i  = 2'($urandom());
      bus.sp_rasctl_i = 2'($urandom());
      bus.sp_brpc_i   = {$urandom(), $urandom()};
      bus.sp_brtar_i  = {$urandom(), $urandom()};
      if (acc || !bus.rt_valid_i) begin
        bus.rt_valid_i = ($urandom_range(0, 3) != 0);
        bus.rt_brdir_i = 1'($urandom());
        bus.rt_brpc_i  = {$urandom(), $urandom()};
        bus.rt_tar_i   = {$urandom(), $urandom()};
      end
      acc = reset_n && bus.rt_valid_i && m_ready();
      step();
    end
    idle_inputs();
    reset_n = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_wr_arb.md
Name: btb_wr_arb

Overview:
- Sits between fetch1 / retire and the single-write-port BTB way.
- Arbitrates speculative BTB allocations from fetch1 against retire-stage counter/target updates, so that at most one BTB write enable is asserted per cycle.
- Speculative allocations are hints and may be dropped.
- Retire updates are lossless: they are held in an in-order FIFO with a valid/ready handshake, and a starvation counter guarantees they drain.

Parameters:
- RT_DEPTH, 4, retire update FIFO depth (power of 2, >=2).
- STARVE_MAX, 3, consecutive speculative grants allowed while retire work is pending.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- flush_i  in  1  fetch redirect; discards the pending speculative entry
- sp_req_i  in  1  fetch1 requests BTB allocation
- sp_brpos_i  in  3  branch position in bundle
- sp_brtyp_i  in  2  branch type
- sp_brpc_i  in  64  bundle PC
- sp_brtar_i  in  64  predicted target
- sp_rasctl_i  in  2  RAS control
- rt_valid_i  in  1  retire update valid
- rt_ready_o  out  1  retire FIFO can accept
- rt_brdir_i  in  1  resolved direction
- rt_brpc_i  in  64  retired bundle PC
- rt_tar_i  in  64  resolved taken address
- btb_sp_we_o  out  1  BTB speculative write enable
- btb_sp_brpos_o  out  3  to BTB
- btb_sp_brtyp_o  out  2  to BTB
- btb_sp_brpc_o  out  64  to BTB
- btb_sp_brtar_o  out  64  to BTB
- btb_ras_ctl_o  out  2  to BTB
- btb_rt_we_o  out  1  BTB retire write enable
- btb_rt_brdir_o  out  1  to BTB
- btb_rt_brpc_o  out  64  to BTB
- btb_taken_addr_o  out  64  to BTB taken-address input
- sp_drop_o  out  1  one-cycle pulse when a valid speculative entry is overwritten unwritten

Behaviour:

State:
- sp_vld plus a speculative holding register.
- Retire FIFO: rd/wr pointers and count.
- starve counter, width clog2(STARVE_MAX+1).

Outputs:
- All outputs are functions of registered state only; there is no input-to-output combinational path.
- Reset: every output is 0, including rt_ready_o while reset_n=0. After reset, rt_ready_o=1.

Latency:
- Request accepted at edge N is presented to the BTB during cycle N+1 at the earliest.

Grant (evaluated on current state each cycle):
- RT if the FIFO is non-empty AND (count==RT_DEPTH OR starve==STARVE_MAX OR !sp_vld).
- Otherwise SP if sp_vld.
- Otherwise none.
- btb_sp_we_o and btb_rt_we_o are never both 1.

Write-port data:
- btb_sp_* fields are driven from the holding register, masked to 0 when there is no SP grant.
- btb_rt_* / btb_taken_addr_o are driven from the FIFO head, masked to 0 when there is no RT grant.

Speculative holding register, at each edge (if/else priority in this order):
1. flush_i=1: sp_vld<=0. Any simultaneous sp_req_i is discarded. No sp_drop_o pulse.
2. sp_req_i=1: load the new entry, sp_vld<=1. If sp_vld=1 and SP was not granted this cycle, pulse sp_drop_o next cycle (newest wins).
3. SP granted: sp_vld<=0.

Retire FIFO:
- rt_ready_o = (count<RT_DEPTH), derived from registered count.
- Push on rt_valid_i && rt_ready_o.
- Pop on RT grant.
- Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo RT_DEPTH.
- FIFO is not affected by flush_i and preserves order.
- rt_valid_i while rt_ready_o=0 is ignored; the producer holds it.

Starvation counter:
- starve<=0 on RT grant or when the FIFO is empty.
- starve<=starve+1 (saturating at STARVE_MAX) on SP grant while the FIFO is non-empty.

Reset mid-operation:
- Clears sp_vld, the FIFO, starve and all outputs at the next edge.
- Pending updates are lost; that is permitted.

Decomposition:
- Shared package (btb_pkg): BR_COND, BR_UNCOND, BR_INDIR_RAS, BR_INDIR_PC branch-type encodings; widths BR_POS_W=3, BR_TYP_W=2, RAS_CTL_W=2, PC_W=64; grant encoding (GNT_NONE/GNT_SP/GNT_RT).
- One sub-module: btb_rt_fifo, a synchronous FIFO of {brdir, brpc, tar} (129 bits) with push/pop/full/empty/count, parameterised by RT_DEPTH.

Test Plan:
1. Reset, then a single sp_req_i with brpc=0x1000, tar=0x2000, brtyp=BR_COND -> next cycle btb_sp_we_o=1 with the same fields for exactly one cycle; btb_rt_we_o=0.
2. Push retire updates pc=0x40,0x80,0xC0 on back-to-back cycles, no sp traffic -> btb_rt_we_o=1 for three consecutive cycles, starting the cycle after the first push, with pcs in order 0x40,0x80,0xC0.
3. Retire FIFO holds 1 entry; sp_req_i held high with distinct pcs every cycle -> exactly 3 consecutive SP grants, then one RT grant; sp_drop_o pulses on each cycle an ungranted pending entry is overwritten.
4. Push 4 retire updates while sp_req_i is continuous -> count=4, rt_ready_o=0, the RT grant comes the next cycle regardless of starve, and rt_ready_o returns to 1 on the following cycle.
5. sp_req_i pc=0x500 at edge N, flush_i=1 with sp_req_i pc=0x600 at edge N+1 -> btb_sp_we_o=0 at N+2, no sp_drop_o, and pc 0x600 is never written.
6. reset_n=0 for one cycle while the FIFO holds 2 entries and sp_vld=1 -> all outputs 0 the following cycle, rt_ready_o=0 during reset and 1 afterwards, and no write enable asserts without new requests.
